// File: rtl/tge_ss_pkg.sv
// Shared types and default sizing for the 10GbE TX snapshot capture controller.
package tge_ss_pkg;

   localparam int DIN_WIDTH_DEF  = 64;
   localparam int ADDR_WIDTH_DEF = 13;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARMED,
      ST_CAPTURE,
      ST_DONE
   } ss_state_e;

endpackage

// File: rtl/tge_txs_ss_ctrl_pack.sv
// Pairs consecutive accepted TX samples into one double-width BRAM word (first sample in the upper half).
module ss_pack64to128 #(
   parameter int DIN_WIDTH = 64
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [DIN_WIDTH-1:0]   din,
   input  logic                   din_we,
   input  logic                   clr,
   output logic [2*DIN_WIDTH-1:0] word,
   output logic                   word_vld
);

   logic                 phase_q, phase_d;
   logic [DIN_WIDTH-1:0] hi_q, hi_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= 1'b0;
         hi_q    <= '0;
      end else begin
         phase_q <= phase_d;
         hi_q    <= hi_d;
      end
   end

   // word is only meaningful while word_vld is high; the second sample is taken straight from din.
   always_comb begin
      phase_d  = phase_q;
      hi_d     = hi_q;
      word_vld = 1'b0;
      if (clr) begin
         phase_d = 1'b0;
      end else if (din_we) begin
         if (!phase_q) begin
            hi_d    = din;
            phase_d = 1'b1;
         end else begin
            word_vld = 1'b1;
            phase_d  = 1'b0;
         end
      end
   end

   assign word = {hi_q, din};

endmodule

// File: rtl/tge_txs_ss_ctrl.sv
// Snapshot capture of the 10GbE TX sample stream into a BRAM, armed by ctrl_arm and started by trigger.
//  state      | meaning
//  ST_IDLE    | after reset, waiting for the first arm edge
//  ST_ARMED   | count cleared, waiting for trig (or immediate when ctrl_trig_src=1)
//  ST_CAPTURE | pairing samples and writing one word per pair
//  ST_DONE    | buffer full, writes stopped until re-armed
module tge_txs_ss_ctrl
   import tge_ss_pkg::*;
#(
   parameter int DIN_WIDTH  = DIN_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [DIN_WIDTH-1:0]   din,
   input  logic                   din_we,
   input  logic                   trig,
   input  logic                   ctrl_arm,
   input  logic                   ctrl_trig_src,
   output logic                   bram_we,
   output logic                   bram_en_a,
   output logic [ADDR_WIDTH-1:0]  bram_addr,
   output logic [2*DIN_WIDTH-1:0] bram_wr_data,
   output logic [ADDR_WIDTH:0]    status_addr,
   output logic                   status_done
);

   localparam logic [ADDR_WIDTH:0] LAST_WORD = {1'b0, {ADDR_WIDTH{1'b1}}};

   ss_state_e              state_q, state_d;
   logic                   arm_prev_q;
   logic [ADDR_WIDTH:0]    cnt_q, cnt_d;
   logic                   done_q, done_d;
   logic                   we_q, we_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [2*DIN_WIDTH-1:0] data_q, data_d;

   logic                   arm_edge;
   logic                   cap_we;
   logic [2*DIN_WIDTH-1:0] word;
   logic                   word_vld;

   assign arm_edge = ctrl_arm & ~arm_prev_q;

   // The trigger cycle itself already captures, hence the ARMED term.
   assign cap_we = din_we & ~arm_edge &
                   ((state_q == ST_CAPTURE) ||
                    ((state_q == ST_ARMED) && (ctrl_trig_src || trig)));

   ss_pack64to128 #(
      .DIN_WIDTH (DIN_WIDTH)
   ) u_pack (
      .clk      (clk),
      .rst_n    (rst_n),
      .din      (din),
      .din_we   (cap_we),
      .clr      (arm_edge),
      .word     (word),
      .word_vld (word_vld)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         arm_prev_q <= 1'b0;
         cnt_q      <= '0;
         done_q     <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
      end else begin
         state_q    <= state_d;
         arm_prev_q <= ctrl_arm;
         cnt_q      <= cnt_d;
         done_q     <= done_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = done_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      if (arm_edge) begin
         state_d = ST_ARMED;
         cnt_d   = '0;
         done_d  = 1'b0;
      end else begin
         case (state_q)
            ST_ARMED: if (ctrl_trig_src || trig) state_d = ST_CAPTURE;
            default:  ;
         endcase
         if (word_vld) begin
            we_d   = 1'b1;
            addr_d = cnt_q[ADDR_WIDTH-1:0];
            data_d = word;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == LAST_WORD) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end
         end
      end
   end

   assign bram_we      = we_q;
   assign bram_en_a    = we_q;
   assign bram_addr    = addr_q;
   assign bram_wr_data = data_q;
   assign status_addr  = cnt_q;
   assign status_done  = done_q;

endmodule

// File: tb/tb_tge_txs_ss_ctrl.sv
// Randomized and directed stimulus for tge_txs_ss_ctrl, checked against a sample-queue reference model.
module tb_tge_txs_ss_ctrl;

   localparam int DW    = 64;
   localparam int AW    = 13;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] din = '0;
   logic          din_we = 1'b0;
   logic          trig = 1'b0;
   logic          ctrl_arm = 1'b0;
   logic          ctrl_trig_src = 1'b0;
   logic          bram_we;
   logic          bram_en_a;
   logic [AW-1:0] bram_addr;
   logic [2*DW-1:0] bram_wr_data;
   logic [AW:0]   status_addr;
   logic          status_done;

   tge_txs_ss_ctrl #(.DIN_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .din           (din),
      .din_we        (din_we),
      .trig          (trig),
      .ctrl_arm      (ctrl_arm),
      .ctrl_trig_src (ctrl_trig_src),
      .bram_we       (bram_we),
      .bram_en_a     (bram_en_a),
      .bram_addr     (bram_addr),
      .bram_wr_data  (bram_wr_data),
      .status_addr   (status_addr),
      .status_done   (status_done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   string tag = "reset";

   // Reference model: samples accepted since the last arm; every second one completes a word.
   logic [DW-1:0]   samp[$];
   int              written;
   bit              m_armed, m_capt, m_full, m_prev_arm;
   bit              exp_we;
   logic [AW-1:0]   exp_addr;
   logic [2*DW-1:0] exp_data;
   bit              arm_l, src_l;
   int              wr_seen;

   task automatic model_reset();
      samp.delete();
      written    = 0;
      m_armed    = 0;
      m_capt     = 0;
      m_full     = 0;
      m_prev_arm = 0;
      exp_we     = 0;
      exp_addr   = '0;
      exp_data   = '0;
   endtask

   task automatic model_step(input bit we, input logic [DW-1:0] d, input bit trg,
                             input bit arm, input bit src);
      bit edge_seen;
      edge_seen  = arm && !m_prev_arm;
      m_prev_arm = arm;
      exp_we     = 0;
      if (edge_seen) begin
         m_armed = 1;
         m_capt  = 0;
         m_full  = 0;
         written = 0;
         samp.delete();
      end else begin
         if (m_armed && !m_capt && (src || trg)) m_capt = 1;
         if (m_capt && !m_full && we) begin
            samp.push_back(d);
            if (samp.size() % 2 == 0) begin
               exp_we   = 1;
               exp_addr = written[AW-1:0];
               exp_data = {samp[samp.size()-2], samp[samp.size()-1]};
               written++;
               if (written == DEPTH) m_full = 1;
            end
         end
      end
   endtask

   task automatic check_eq(input string name, input logic [2*DW-1:0] got, input logic [2*DW-1:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s/%s got %0h expected %0h", tag, name, got, exp);
      end
   endtask

   task automatic check_all();
      check_eq("bram_we", {127'd0, bram_we}, {127'd0, exp_we});
      check_eq("bram_en_a", {127'd0, bram_en_a}, {127'd0, exp_we});
      check_eq("bram_addr", {115'd0, bram_addr}, {115'd0, exp_addr});
      check_eq("bram_wr_data", bram_wr_data, exp_data);
      check_eq("status_addr", {114'd0, status_addr}, 128'(written));
      check_eq("status_done", {127'd0, status_done}, {127'd0, m_full});
      if (bram_we === 1'b1) wr_seen++;
   endtask

   task automatic cyc(input bit we, input logic [DW-1:0] d, input bit trg);
      din_we        = we;
      din           = d;
      trig          = trg;
      ctrl_arm      = arm_l;
      ctrl_trig_src = src_l;
      model_step(we, d, trg, arm_l, src_l);
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   task automatic arm_pulse();
      arm_l = 0;
      cyc(0, '0, 0);
      arm_l = 1;
      cyc(0, '0, 0);
   endtask

   function automatic logic [DW-1:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   initial begin
      int guard;
      model_reset();
      arm_l   = 0;
      src_l   = 0;
      wr_seen = 0;
      repeat (2) @(negedge clk);
      check_all();
      rst_n = 1'b1;

      tag = "idle_ignore";
      src_l = 1;
      for (int i = 0; i < 4; i++) cyc(1, rnd64(), 1);

      tag = "src1_basic";
      arm_pulse();
      for (int i = 1; i <= 4; i++) cyc(1, DW'(i), 0);
      cyc(0, '0, 0);
      check_eq("two_words", 128'(status_addr), 128'd2);

      tag = "src0_trig";
      src_l = 0;
      arm_pulse();
      for (int i = 0; i < 5; i++) cyc(1, rnd64(), 0);
      check_eq("no_write_pre_trig", 128'(status_addr), 128'd0);
      cyc(1, 64'hA, 1);
      cyc(1, 64'hB, 0);
      cyc(0, '0, 0);
      check_eq("first_word", bram_wr_data, {64'hA, 64'hB});

      tag = "rearm_mid_pair";
      src_l = 1;
      arm_pulse();
      for (int i = 1; i <= 3; i++) cyc(1, DW'(i), 0);
      arm_l = 0;
      cyc(0, '0, 0);
      arm_l = 1;
      cyc(0, '0, 0);
      cyc(1, 64'd7, 0);
      cyc(1, 64'd8, 0);
      cyc(0, '0, 0);

      tag = "arm_on_second";
      cyc(1, rnd64(), 0);
      arm_l = 0;
      cyc(0, '0, 0);
      arm_l = 1;
      cyc(1, rnd64(), 0);
      cyc(0, '0, 0);
      check_eq("arm_wins", 128'(status_addr), 128'd0);

      tag = "gapped";
      cyc(1, 64'h11, 0);
      cyc(0, '0, 0);
      cyc(0, '0, 0);
      cyc(1, 64'h44, 0);
      cyc(0, '0, 0);

      tag = "random";
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 15) == 0) arm_l = ~arm_l;
         if ($urandom_range(0, 31) == 0) src_l = ~src_l;
         cyc($urandom_range(0, 1) == 1, rnd64(), $urandom_range(0, 7) == 0);
      end

      tag = "full_buffer";
      src_l = 1;
      arm_pulse();
      guard = 0;
      while (!m_full && guard < 40000) begin
         cyc($urandom_range(0, 7) != 0, rnd64(), $urandom_range(0, 1) == 1);
         guard++;
      end
      check_eq("fill_in_budget", {127'd0, m_full}, 128'd1);
      check_eq("done_flag", {127'd0, status_done}, 128'd1);
      check_eq("final_count", 128'(status_addr), 128'(DEPTH));
      check_eq("last_addr", 128'(bram_addr), 128'(DEPTH - 1));
      wr_seen = 0;
      for (int i = 0; i < 4; i++) cyc(1, rnd64(), 1);
      cyc(0, '0, 0);
      check_eq("no_write_after_done", 128'(wr_seen), 128'd0);

      tag = "async_reset";
      arm_pulse();
      for (int i = 0; i < 5; i++) cyc(1, rnd64(), 0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      arm_l = 0;
      @(negedge clk);
      rst_n = 1'b1;
      wr_seen = 0;
      for (int i = 0; i < 6; i++) cyc(1, rnd64(), 1);
      check_eq("no_write_before_arm", 128'(wr_seen), 128'd0);
      arm_pulse();
      for (int i = 0; i < 6; i++) cyc(1, rnd64(), 0);
      cyc(0, '0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
